// File: rtl/dwc_pkg.sv
// dwc_pkg: shared state encoding and default widths for detect_window_counter.
`default_nettype none

package dwc_pkg;

  localparam int DWC_WIN_W = 8;
  localparam int DWC_CNT_W = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } dwc_state_t;

endpackage

`default_nettype wire

// File: rtl/dwc_sat_counter.sv
// dwc_sat_counter: CNT_W-bit saturating event counter with synchronous clear.
`default_nettype none

module dwc_sat_counter
  import dwc_pkg::*;
#(
  parameter int CNT_W = DWC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] next_count
);

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;

  logic [CNT_W-1:0] count;

  // next_count is the value including this cycle's increment, so a window
  // close can capture it while the register itself is being cleared.
  always_comb begin
    next_count = count;
    if (inc && (count != MAX_COUNT)) next_count = count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else          count <= next_count;
  end

endmodule

`default_nettype wire

// File: rtl/detect_window_counter.sv
// detect_window_counter: counts y_in pulses per programmable window, presents results on valid/ready.
// Optional sticky overrun flag enabled by macro DWC_OVERRUN_EN.
`default_nettype none

module detect_window_counter
  import dwc_pkg::*;
#(
  parameter int WIN_W = DWC_WIN_W,
  parameter int CNT_W = DWC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready
`ifdef DWC_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  dwc_state_t       state;
  logic [WIN_W-1:0] win_cnt;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] len_in;
  logic [CNT_W-1:0] evt_next;
  logic             run_active;
  logic             win_last;
  logic             close;
  logic             evt_clr;
  logic             accept;
  logic             load;

  assign len_in     = (win_len == '0) ? WIN_W'(1) : win_len;
  assign run_active = (state == RUN) && enable;
  assign win_last   = (win_cnt == (len_q - 1'b1));
  assign close      = run_active && win_last;
  assign evt_clr    = !run_active || win_last;
  assign accept     = cnt_valid && cnt_ready;
  // A close replaces the held result only if the slot is empty or being accepted now.
  assign load       = close && (!cnt_valid || cnt_ready);

  dwc_sat_counter #(
    .CNT_W (CNT_W)
  ) u_evt_cnt (
    .clk        (clk),
    .reset      (reset),
    .clr        (evt_clr),
    .inc        (y_in),
    .next_count (evt_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      win_cnt <= '0;
      len_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          win_cnt <= '0;
          if (enable) begin
            state <= RUN;
            len_q <= len_in;
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            win_cnt <= '0;
          end else if (win_last) begin
            win_cnt <= '0;
            len_q   <= len_in;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          win_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_data  <= '0;
      cnt_valid <= 1'b0;
    end else if (load) begin
      cnt_data  <= evt_next;
      cnt_valid <= 1'b1;
    end else if (accept) begin
      cnt_valid <= 1'b0;
    end
  end

`ifdef DWC_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  overrun <= 1'b0;
    else if (close && cnt_valid && !cnt_ready)  overrun <= 1'b1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_detect_window_counter.sv
// tb_detect_window_counter: directed self-checking bench for detect_window_counter.
`default_nettype none

module tb_detect_window_counter;

  logic       clk;
  logic       reset;
  logic       y_in;
  logic       enable;
  logic [7:0] win_len;
  logic       cnt_ready;
  logic [7:0] cnt_data;
  logic       cnt_valid;
  logic [3:0] s_cnt_data;
  logic       s_cnt_valid;
`ifdef DWC_OVERRUN_EN
  logic       overrun;
  logic       s_overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  detect_window_counter #(.WIN_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .enable    (enable),
    .win_len   (win_len),
    .cnt_data  (cnt_data),
    .cnt_valid (cnt_valid),
    .cnt_ready (cnt_ready)
`ifdef DWC_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  detect_window_counter #(.WIN_W(8), .CNT_W(4)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .y_in      (y_in),
    .enable    (enable),
    .win_len   (win_len),
    .cnt_data  (s_cnt_data),
    .cnt_valid (s_cnt_valid),
    .cnt_ready (cnt_ready)
`ifdef DWC_OVERRUN_EN
    ,
    .overrun   (s_overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic [7:0] len);
    enable = 1'b0;
    cyc();
    win_len = len;
    enable  = 1'b1;
    cyc();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; win_len = 8'd0; y_in = 1'b0; cnt_ready = 1'b0;
    repeat (2) cyc();
    check("rst_valid", 32'(cnt_valid), 0);
    check("rst_data", 32'(cnt_data), 0);
`ifdef DWC_OVERRUN_EN
    check("rst_overrun", 32'(overrun), 0);
`endif
    reset = 1'b0;

    // Basic window of 4 with pattern 1,0,1,1
    cnt_ready = 1'b1;
    restart(8'd4);
    y_in = 1'b1; cyc();
    y_in = 1'b0; cyc();
    y_in = 1'b1; cyc();
    check("t1_not_yet", 32'(cnt_valid), 0);
    y_in = 1'b1; cyc();
    check("t1_valid", 32'(cnt_valid), 1);
    check("t1_data", 32'(cnt_data), 3);
    y_in = 1'b0; cyc();
    check("t1_accepted", 32'(cnt_valid), 0);

    // win_len = 0 behaves as L=1: data follows previous cycle's y_in
    restart(8'd0);
    y_in = 1'b1; cyc();
    check("l1_valid", 32'(cnt_valid), 1);
    check("l1_data_a", 32'(cnt_data), 1);
    y_in = 1'b0; cyc();
    check("l1_data_b", 32'(cnt_data), 0);
    y_in = 1'b1; cyc();
    check("l1_data_c", 32'(cnt_data), 1);

    // Saturation: CNT_W=4 instance over a 20-cycle window
    y_in = 1'b0;
    restart(8'd20);
    y_in = 1'b1;
    repeat (19) cyc();
    check("sat_not_yet", 32'(s_cnt_valid), 0);
    cyc();
    check("sat_valid", 32'(s_cnt_valid), 1);
    check("sat_data", 32'(s_cnt_data), 15);
    check("wide_data", 32'(cnt_data), 20);

    // Drop: consumer stalled across several closes
    pulse_reset();
    cnt_ready = 1'b0; y_in = 1'b1;
    restart(8'd4);
    repeat (4) cyc();
    check("drop_first_valid", 32'(cnt_valid), 1);
    check("drop_first_data", 32'(cnt_data), 4);
`ifdef DWC_OVERRUN_EN
    check("drop_ovr_before", 32'(overrun), 0);
`endif
    repeat (4) cyc();
`ifdef DWC_OVERRUN_EN
    check("drop_ovr_after", 32'(overrun), 1);
`endif
    y_in = 1'b0;
    repeat (8) cyc();
    check("drop_held_data", 32'(cnt_data), 4);
    check("drop_held_valid", 32'(cnt_valid), 1);

    // Acceptance coinciding with a close replaces the result
    pulse_reset();
    cnt_ready = 1'b0;
    y_in = 1'b0;
    restart(8'd4);
    y_in = 1'b1; cyc();
    y_in = 1'b1; cyc();
    y_in = 1'b0; cyc();
    y_in = 1'b0; cyc();
    check("co_first_data", 32'(cnt_data), 2);
    y_in = 1'b1; cyc();
    y_in = 1'b0; cyc();
    cyc();
    cnt_ready = 1'b1; cyc();
    check("co_valid", 32'(cnt_valid), 1);
    check("co_data", 32'(cnt_data), 1);
`ifdef DWC_OVERRUN_EN
    check("co_overrun", 32'(overrun), 0);
`endif
    cyc();
    check("co_drained", 32'(cnt_valid), 0);

    // Enable drop mid-window keeps a pending result and yields no new one
    pulse_reset();
    cnt_ready = 1'b0; y_in = 1'b1;
    restart(8'd4);
    repeat (4) cyc();
    y_in = 1'b0;
    cyc(); cyc();
    enable = 1'b0; y_in = 1'b1;
    cyc();
    repeat (5) cyc();
    check("en_pending_valid", 32'(cnt_valid), 1);
    check("en_pending_data", 32'(cnt_data), 4);
    cnt_ready = 1'b1;
    cyc();
    check("en_accepted", 32'(cnt_valid), 0);
    repeat (6) cyc();
    check("en_no_result", 32'(cnt_valid), 0);

    // Async reset mid-window with a pending result
    cnt_ready = 1'b0; y_in = 1'b1;
    restart(8'd4);
    repeat (4) cyc();
    cyc(); cyc();
    #3 reset = 1'b1;
    #1;
    check("ar_valid", 32'(cnt_valid), 0);
    check("ar_data", 32'(cnt_data), 0);
`ifdef DWC_OVERRUN_EN
    check("ar_overrun", 32'(overrun), 0);
`endif
    #2 reset = 1'b0;
    cnt_ready = 1'b1;
    restart(8'd2);
    cyc(); cyc();
    check("ar_restart_valid", 32'(cnt_valid), 1);
    check("ar_restart_data", 32'(cnt_data), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
